// File: rtl/tristate_bus_arbiter_if.sv
// Bus bundle shared by the four-way tristate arbiter and its requesters.
// The master modport is the arbiter side: it sees the requests and drives
// the one-hot tristate enables, the encoded owner and the status flags.
// The slave modport is the requester/mux side.
interface tristate_bus_arbiter_if;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       bus_active;
  logic       timeout;

  modport master (
    input  req,
    output grant,
    output sel,
    output bus_active,
    output timeout
  );

  modport slave (
    output req,
    input  grant,
    input  sel,
    input  bus_active,
    input  timeout
  );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter for a 4-input tristate-muxed line.
// grant is the one-hot (or all-zero) set of bufif1 enables, sel the encoded
// current/last owner, and timeout pulses when an owner is pushed off the bus
// after MAX_HOLD consecutive cycles.
// Optional feature macro: ARB_TURNAROUND_EN. When defined, a one-cycle
// all-drivers-off TURN state separates any two grants (even a regrant to the
// same requester). When undefined, release and the next grant share an edge.
module tristate_bus_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  tristate_bus_arbiter_if.master bus
);

`ifdef ARB_TURNAROUND_EN
  typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, TURN = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1} state_t;
`endif

  state_t           state_q;
  logic [3:0]       grant_q;
  logic [1:0]       sel_q;
  logic             busActive_q;
  logic             timeout_q;
  logic [CNT_W-1:0] holdCount_q;
  logic [1:0]       rrPtr_q;

  logic             winFound;
  logic [1:0]       winIdx;
  logic [1:0]       candIdx;
  logic             ownerReq;
  logic             holdDone;
  logic             releaseNow;

  // Round-robin search: first set request starting at the pointer, wrapping.
  always_comb begin
    winFound = 1'b0;
    winIdx   = rrPtr_q;
    candIdx  = rrPtr_q;
    for (int k = 0; k < 4; k++) begin
      candIdx = rrPtr_q + 2'(k);
      if (!winFound && bus.req[candIdx]) begin
        winFound = 1'b1;
        winIdx   = candIdx;
      end
    end
  end

  assign ownerReq   = bus.req[sel_q];
  assign holdDone   = (holdCount_q == CNT_W'(MAX_HOLD));
  assign releaseNow = !ownerReq || holdDone;

  // Single-process FSM: ownership tracking, hold limit and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= 4'b0000;
      sel_q       <= 2'b00;
      busActive_q <= 1'b0;
      timeout_q   <= 1'b0;
      holdCount_q <= '0;
      rrPtr_q     <= 2'b00;
    end else begin
      timeout_q <= 1'b0;
      if (state_q == OWN && !releaseNow) begin
        holdCount_q <= holdCount_q + CNT_W'(1);
      end else begin
        if (state_q == OWN) begin
          timeout_q <= ownerReq && holdDone;
        end
`ifdef ARB_TURNAROUND_EN
        if (state_q == OWN) begin
          grant_q     <= 4'b0000;
          busActive_q <= 1'b0;
          holdCount_q <= '0;
          state_q     <= TURN;
        end else
`endif
        if (winFound) begin
          grant_q     <= 4'b0001 << winIdx;
          sel_q       <= winIdx;
          busActive_q <= 1'b1;
          holdCount_q <= CNT_W'(1);
          rrPtr_q     <= winIdx + 2'd1;
          state_q     <= OWN;
        end else begin
          grant_q     <= 4'b0000;
          busActive_q <= 1'b0;
          holdCount_q <= '0;
          state_q     <= IDLE;
        end
      end
    end
  end

  assign bus.grant      = grant_q;
  assign bus.sel        = sel_q;
  assign bus.bus_active = busActive_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Scoreboard bench for tristate_bus_arbiter.
// Stimulus drives req/rst on the falling edge and pushes the reference
// model's prediction for the following rising edge into a queue; a separate
// monitor pops one entry per cycle just after the rising edge and compares.
module tb_tristate_bus_arbiter;
  localparam int TB_MAX_HOLD = 3;
  localparam int TB_CNT_W    = 4;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] sel;
    logic       active;
    logic       tout;
  } exp_t;

  logic clk;
  logic rst;
  exp_t expQ[$];
  int   checks;
  int   errors;

  // Reference model state, in terms of ownership rather than FSM encoding.
  int   mOwner;
  int   mTenure;
  int   mPtr;
  int   mLastSel;
  bit   mTurnPending;
  bit   mTout;

  tristate_bus_arbiter_if busIf ();

  tristate_bus_arbiter #(
    .MAX_HOLD(TB_MAX_HOLD),
    .CNT_W   (TB_CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(busIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Give the bus to the first requester at or after the pointer, wrapping.
  function automatic void modelArbitrate(input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (mPtr + k) % 4;
      if (r[i]) begin
        mOwner   = i;
        mLastSel = i;
        mTenure  = 1;
        mPtr     = (i + 1) % 4;
        return;
      end
    end
    mOwner = -1;
  endfunction

  // Advance the model by one rising edge given the inputs seen at that edge.
  function automatic void modelStep(input logic [3:0] r, input logic rs);
    if (rs) begin
      mOwner = -1; mTenure = 0; mPtr = 0; mLastSel = 0;
      mTurnPending = 0; mTout = 0;
      return;
    end
    mTout = 0;
    if (mOwner >= 0) begin
      if (!r[mOwner] || mTenure == TB_MAX_HOLD) begin
        mTout  = r[mOwner] && (mTenure == TB_MAX_HOLD);
        mOwner = -1;
`ifdef ARB_TURNAROUND_EN
        mTurnPending = 1;
`else
        modelArbitrate(r);
`endif
      end else begin
        mTenure++;
      end
    end else if (mTurnPending) begin
      mTurnPending = 0;
      modelArbitrate(r);
    end else begin
      modelArbitrate(r);
    end
  endfunction

  task automatic applyStimulus(input logic [3:0] r, input logic rs);
    exp_t e;
    @(negedge clk);
    busIf.req = r;
    rst       = rs;
    modelStep(r, rs);
    e.grant  = (mOwner >= 0) ? (4'b0001 << mOwner) : 4'b0000;
    e.sel    = 2'(mLastSel);
    e.active = (mOwner >= 0);
    e.tout   = mTout;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (busIf.grant !== e.grant) begin
      errors++;
      $display("[TB] FAIL grant: got %b expected %b at %0t", busIf.grant, e.grant, $time);
    end
    checks++;
    if (busIf.sel !== e.sel) begin
      errors++;
      $display("[TB] FAIL sel: got %b expected %b at %0t", busIf.sel, e.sel, $time);
    end
    checks++;
    if (busIf.bus_active !== e.active) begin
      errors++;
      $display("[TB] FAIL bus_active: got %b expected %b at %0t", busIf.bus_active, e.active, $time);
    end
    checks++;
    if (busIf.timeout !== e.tout) begin
      errors++;
      $display("[TB] FAIL timeout: got %b expected %b at %0t", busIf.timeout, e.tout, $time);
    end
    checks++;
    if (!$onehot0(busIf.grant)) begin
      errors++;
      $display("[TB] FAIL grant_onehot: got %b expected 0000 or one-hot at %0t", busIf.grant, $time);
    end
  endtask

  // Monitor: one prediction per rising edge, compared just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  // Stimulus: directed scenarios, then sticky random requests with rare resets.
  initial begin
    logic [3:0] reqState;
    checks = 0;
    errors = 0;
    mOwner = -1; mTenure = 0; mPtr = 0; mLastSel = 0;
    mTurnPending = 0; mTout = 0;
    rst = 1'b1;
    busIf.req = 4'b0000;

    $display("[TB] reset with all requests high");
    repeat (3) applyStimulus(4'b1111, 1'b1);
    $display("[TB] round-robin rotation");
    repeat (14) applyStimulus(4'b1111, 1'b0);
    repeat (2) applyStimulus(4'b0000, 1'b0);
    $display("[TB] voluntary release");
    repeat (2) applyStimulus(4'b0100, 1'b0);
    repeat (3) applyStimulus(4'b0000, 1'b0);
    $display("[TB] contention");
    applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b1001, 1'b0);
    repeat (4) applyStimulus(4'b1000, 1'b0);
    repeat (2) applyStimulus(4'b0000, 1'b0);
    $display("[TB] reset mid-grant");
    repeat (2) applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0001, 1'b1);
    repeat (3) applyStimulus(4'b0110, 1'b0);
    repeat (2) applyStimulus(4'b0000, 1'b0);

    $display("[TB] random requests");
    reqState = 4'b0000;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) reqState[b] = ~reqState[b];
      end
      applyStimulus(reqState, ($urandom_range(0, 299) == 0));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tristate_bus_arbiter.md
# tristate_bus_arbiter

Round-robin arbiter that shares one tristate-muxed line among four requesters. It produces the one-hot `grant[3:0]` vector that drives the `bufif1` enables of a 4-input tristate mux, along with the encoded `sel`. It guarantees that at most one driver is ever enabled, bounds ownership with a hold-time limit, and can insert a bus-turnaround (all-drivers-off) cycle between owners.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one requester may own the bus. Legal range is 1 to 2^CNT_W−1.
- `CNT_W`, default 4: width of the hold counter.
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req`, input, 4: request per requester; held high for as long as bus ownership is wanted.
- `grant`, output, 4: one-hot (or all-zero) tristate enables, registered. Bit i drives enable i of the mux.
- `sel`, output, 2: encoded index of the current owner, or of the last owner while idle/turnaround. Registered.
- `bus_active`, output, 1: OR of `grant`; when low, the shared line floats (z).
- `timeout`, output, 1: one-cycle pulse on a forced release at `MAX_HOLD`.

## Operation
- **States:** IDLE, OWN, TURN (TURN exists only with `ARB_TURNAROUND_EN`).
- **Reset values:** state IDLE, `grant`=0000, `sel`=00, `bus_active`=0, `timeout`=0, hold count 0, round-robin pointer 0 (req[0] has top priority after reset).
- **Arbitration:** search `req` starting at the pointer and wrapping modulo 4. The first set bit wins. After each grant, pointer = winner+1 mod 4, so the previous owner ranks last.
- **IDLE:**
  - Any req set → winner's grant bit set, `sel`=winner, count=1, go to OWN.
  - No req → stay in IDLE with grant=0000.
- **OWN:**
  - `req[owner]` low → release.
  - Otherwise, count==MAX_HOLD → forced release with `timeout`=1 for one cycle.
  - Otherwise → count+1, grant unchanged.
  - Requests from non-owners are ignored until release.
- **Release:**
  - `grant`→0000. `sel` keeps the old owner.
  - Next state is TURN if the macro is defined. Otherwise re-arbitrate on the same edge (see Configuration).
- **TURN:** lasts exactly one cycle with grant=0000. At the end, arbitration runs as in IDLE → OWN or IDLE.
- **Forced-release owner:** it may be regranted only if no other requester is pending, because the round-robin order places it last.
- **Invariants:**
  - `grant` is always 0000 or one-hot.
  - `grant` is never 1111 or any multi-hot value, including during reset deassertion.
  - No two different grant bits are ever high in consecutive cycles unless the macro is undefined (direct handoff).
- **Reset mid-ownership:** grant drops to 0000 at the next edge and the pointer returns to 0.

## Timing
- **Grant latency:** req[i] high before edge N in IDLE → grant[i] high after edge N (1 cycle).
- **Release latency:** req[owner] low before edge N → grant low after edge N.
- **Handoff with macro:** new grant appears after edge N+1, so the line floats for exactly 1 cycle.
- **Handoff without macro:** new grant appears after edge N (zero idle cycles).
- **Hold limit:** with `req` held continuously, grant stays high for exactly MAX_HOLD cycles. `timeout` is high in the first cycle that grant is low.
- **MAX_HOLD=1:** every grant lasts 1 cycle. With the macro, a single persistent requester owns the bus 1 cycle out of every 2.
- **Counter width:** the counter never exceeds MAX_HOLD and does not wrap.

## Configuration
- **`ARB_TURNAROUND_EN`:**
  - **Defined:** the TURN state is compiled in, giving one mandatory all-off cycle between any two grants, including a regrant to the same requester after a timeout.
  - **Undefined:** TURN is removed. Release and the next grant occur on the same edge. IDLE is entered only when no req is pending.

## Test plan
- **Reset:** hold `rst` for 3 cycles with req=1111 → grant=0000, sel=00, timeout=0 throughout; grant=0001 one cycle after `rst` falls.
- **Round-robin rotation:** req=1111 held, MAX_HOLD=2, macro defined → grant sequence 0001,0001,0000,0010,0010,0000,0100,… with `timeout` pulsing after each pair.
- **Voluntary release:** req=0100 for 5 cycles, then 0000 → grant=0100 for exactly 5 cycles, then 0000. `timeout` never asserts and sel stays 10.
- **Contention:** while 0001 owns, raise req[3] → grant stays 0001 until req[0] drops. Then 1000 appears 2 edges later (macro) or 1 edge later (no macro).
- **Reset mid-grant:** assert `rst` in the third owned cycle → grant=0000 after that edge. After reset, req=0110 yields grant=0010 (pointer back at 0).
- **Invariant check:** random req for 10k cycles → `grant` is always 0000 or one-hot, and grant-high runs never exceed MAX_HOLD.
